mem_access_stage: RTL and testbench

MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

---
 rtl/mem_access_stage.sv | 188 ++++++++++++++++++
 tb/tb_mem_access_stage.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: issues one data-memory request per aligned load/store,
// stalls upstream while it waits for the ack (bounded by TIMEOUT), and drives the MEM/WB
// register. Misaligned accesses and timeouts raise a sticky error flag.
module mem_access_stage #(
    parameter int unsigned TIMEOUT  = 16,
    parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] ALUResult_i,
    input  logic [31:0] RS2data_i,
    input  logic [31:0] pc_branch_i,
    input  logic        Zero_i,
    input  logic        Branch_i,
    input  logic        MemRead_i,
    input  logic        MemtoReg_i,
    input  logic        MemWrite_i,
    input  logic        RegWrite_i,
    input  logic [4:0]  RDaddr_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [31:0] dmem_wdata_o,
    input  logic        dmem_ack_i,
    input  logic [31:0] dmem_rdata_i,
    output logic        stall_o,
    output logic        PCSrc_o,
    output logic [31:0] pc_branch_o,
    output logic        RegWrite_o,
    output logic        MemtoReg_o,
    output logic [31:0] ReadData_o,
    output logic [31:0] ALUResult_o,
    output logic [4:0]  RDaddr_o,
    output logic        err_o
);

    localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            err_q, err_d;

    logic [31:0] addr_q, wdata_q, rdata_q;
    logic        we_q;

    logic        regwrite_q, memtoreg_q;
    logic [31:0] readdata_q, aluresult_q;
    logic [4:0]  rdaddr_q;

    logic access, aligned;
    logic latch_req, capture, timeout, misalign, wb_load, wb_bubble;

    assign access  = MemRead_i | MemWrite_i;
    assign aligned = (ALUResult_i[1:0] == 2'b00);

    // Branch redirect is purely combinational and independent of the access FSM.
    assign PCSrc_o     = Branch_i & Zero_i;
    assign pc_branch_o = pc_branch_i;

    // Next-state, stall/request strobes and MEM/WB load controls.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        stall_o    = 1'b0;
        dmem_req_o = 1'b0;
        latch_req  = 1'b0;
        capture    = 1'b0;
        timeout    = 1'b0;
        misalign   = 1'b0;
        wb_load    = 1'b0;
        wb_bubble  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (access) begin
                    wb_bubble = 1'b1;
                    if (aligned) begin
                        latch_req = 1'b1;
                        stall_o   = 1'b1;
                        cnt_d     = '0;
                        state_d   = StAccess;
                    end else begin
                        misalign = 1'b1;
                    end
                end else begin
                    wb_load = 1'b1;
                end
            end
            StAccess: begin
                dmem_req_o = 1'b1;
                stall_o    = 1'b1;
                wb_bubble  = 1'b1;
                cnt_d      = cnt_q + CntW'(1);
                // An ack in the last allowed cycle still wins over the timeout.
                if (dmem_ack_i) begin
                    capture = 1'b1;
                    state_d = StDone;
                end else if (cnt_q == CntLast) begin
                    timeout = 1'b1;
                    state_d = StDone;
                end
            end
            StDone: begin
                wb_load = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign err_d = err_q | misalign | timeout;

    // FSM state, wait counter and sticky error flag.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Request registers latched on entry to ACCESS; completion data captured on exit.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            rdata_q <= '0;
        end else begin
            if (latch_req) begin
                addr_q  <= ALUResult_i;
                wdata_q <= RS2data_i;
                we_q    <= MemWrite_i;
            end
            // Stores (including both-flags-set) never return load data.
            if (capture) begin
                rdata_q <= we_q ? '0 : dmem_rdata_i;
            end else if (timeout) begin
                rdata_q <= we_q ? '0 : ERR_DATA;
            end
        end
    end

    // MEM/WB register: real load when the stage advances, bubble otherwise.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            regwrite_q  <= 1'b0;
            memtoreg_q  <= 1'b0;
            readdata_q  <= '0;
            aluresult_q <= '0;
            rdaddr_q    <= '0;
        end else if (wb_load) begin
            regwrite_q  <= RegWrite_i;
            memtoreg_q  <= MemtoReg_i;
            aluresult_q <= ALUResult_i;
            rdaddr_q    <= RDaddr_i;
            // Non-memory ops carry no load data, so ReadData is cleared for them.
            readdata_q  <= (state_q == StDone) ? rdata_q : '0;
        end else if (wb_bubble) begin
            regwrite_q <= 1'b0;
            memtoreg_q <= 1'b0;
            rdaddr_q   <= '0;
        end
    end

    assign dmem_we_o    = we_q;
    assign dmem_addr_o  = addr_q;
    assign dmem_wdata_o = wdata_q;
    assign RegWrite_o   = regwrite_q;
    assign MemtoReg_o   = memtoreg_q;
    assign ReadData_o   = readdata_q;
    assign ALUResult_o  = aluresult_q;
    assign RDaddr_o     = rdaddr_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: a driver issues random and directed
// instructions and pushes expected MEM/WB results; a monitor pops on every retire.
module tb_mem_access_stage;

    localparam int TOUT = 16;
    localparam logic [31:0] ERRD = 32'hDEADBEEF;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [31:0] ALUResult_i, RS2data_i, pc_branch_i;
    logic        Zero_i, Branch_i, MemRead_i, MemtoReg_i, MemWrite_i, RegWrite_i;
    logic [4:0]  RDaddr_i;
    logic        dmem_req_o, dmem_we_o;
    logic [31:0] dmem_addr_o, dmem_wdata_o;
    logic        dmem_ack_i;
    logic [31:0] dmem_rdata_i;
    logic        stall_o, PCSrc_o;
    logic [31:0] pc_branch_o;
    logic        RegWrite_o, MemtoReg_o;
    logic [31:0] ReadData_o, ALUResult_o;
    logic [4:0]  RDaddr_o;
    logic        err_o;

    always #5 clk = ~clk;

    mem_access_stage #(.TIMEOUT(TOUT), .ERR_DATA(ERRD)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .ALUResult_i(ALUResult_i), .RS2data_i(RS2data_i), .pc_branch_i(pc_branch_i),
        .Zero_i(Zero_i), .Branch_i(Branch_i), .MemRead_i(MemRead_i),
        .MemtoReg_i(MemtoReg_i), .MemWrite_i(MemWrite_i), .RegWrite_i(RegWrite_i),
        .RDaddr_i(RDaddr_i),
        .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
        .dmem_wdata_o(dmem_wdata_o), .dmem_ack_i(dmem_ack_i), .dmem_rdata_i(dmem_rdata_i),
        .stall_o(stall_o), .PCSrc_o(PCSrc_o), .pc_branch_o(pc_branch_o),
        .RegWrite_o(RegWrite_o), .MemtoReg_o(MemtoReg_o), .ReadData_o(ReadData_o),
        .ALUResult_o(ALUResult_o), .RDaddr_o(RDaddr_o), .err_o(err_o)
    );

    // ack_k: ack on the k-th ACCESS cycle; 0 means the memory never answers.
    typedef struct {
        logic mr, mw, mtr, rw, br, zero;
        logic [31:0] alu, rs2, pcb, rdata;
        logic [4:0] rd;
        int ack_k;
    } txn_t;

    typedef struct {
        logic rw, mtr, we, err;
        logic [4:0] rd;
        logic [31:0] alu, rdat, addr, wdata;
        int stall;
    } exp_t;

    exp_t sb_q[$];
    int checks = 0;
    int errors = 0;

    // Reference model state: what MEM/WB and the request registers should hold.
    logic [31:0] m_alu = '0, m_rdat = '0, m_addr = '0, m_wdata = '0;
    logic        m_we = 1'b0, m_err = 1'b0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic exp_t model(txn_t t);
        exp_t e;
        int waits;
        logic timed;
        e.rw = 1'b0; e.mtr = 1'b0; e.rd = '0; e.stall = 0;
        if (!(t.mr || t.mw)) begin
            e.rw = t.rw; e.mtr = t.mtr; e.rd = t.rd;
            m_alu = t.alu; m_rdat = '0;
        end else if (t.alu[1:0] != 2'b00) begin
            m_err = 1'b1;
        end else begin
            timed = !(t.ack_k >= 1 && t.ack_k <= TOUT);
            waits = timed ? TOUT : t.ack_k;
            e.stall = 1 + waits;
            e.rw = t.rw; e.mtr = t.mtr; e.rd = t.rd;
            m_alu = t.alu; m_addr = t.alu; m_wdata = t.rs2; m_we = t.mw;
            m_rdat = t.mw ? 32'h0 : (timed ? ERRD : t.rdata);
            if (timed) m_err = 1'b1;
        end
        e.alu = m_alu; e.rdat = m_rdat; e.addr = m_addr; e.wdata = m_wdata;
        e.we = m_we; e.err = m_err;
        return e;
    endfunction

    function automatic txn_t mk(logic mr, logic mw, logic [31:0] alu, logic [31:0] rs2,
                                logic [4:0] rd, logic rw, logic mtr, logic [31:0] rdata,
                                int ack_k);
        txn_t t;
        t.mr = mr; t.mw = mw; t.alu = alu; t.rs2 = rs2; t.rd = rd; t.rw = rw; t.mtr = mtr;
        t.rdata = rdata; t.ack_k = ack_k; t.br = 1'b0; t.zero = 1'b0; t.pcb = $urandom;
        return t;
    endfunction

    function automatic txn_t rand_txn();
        txn_t t;
        int kind;
        kind = $urandom_range(0, 9);
        t = mk(1'b0, 1'b0, $urandom, $urandom, 5'($urandom), 1'($urandom), 1'($urandom),
               $urandom, 0);
        t.br = 1'($urandom); t.zero = 1'($urandom);
        if (kind >= 3) begin
            t.mr = (kind <= 5) || (kind >= 8);
            t.mw = (kind >= 6);
            if (kind == 9) begin
                t.mr = 1'($urandom); t.mw = !t.mr;
                t.alu[1:0] = 2'($urandom_range(1, 3));
            end else begin
                t.alu[1:0] = 2'b00;
            end
            t.ack_k = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 6);
        end
        return t;
    endfunction

    // Drive one instruction (inputs held while stalled) and play the memory side.
    task automatic run_txn(input txn_t t);
        int acc;
        logic st;
        logic done;
        ALUResult_i = t.alu; RS2data_i = t.rs2; pc_branch_i = t.pcb;
        Zero_i = t.zero; Branch_i = t.br; MemRead_i = t.mr; MemWrite_i = t.mw;
        MemtoReg_i = t.mtr; RegWrite_i = t.rw; RDaddr_i = t.rd;
        dmem_ack_i = 1'($urandom); dmem_rdata_i = $urandom;
        sb_q.push_back(model(t));
        acc = 0;
        done = 1'b0;
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge clk);
            st = stall_o;
            @(posedge clk);
            #1;
            if (!st) begin
                done = 1'b1;
            end else begin
                if (dmem_req_o) acc++;
                if (dmem_req_o) begin
                    dmem_ack_i = (acc == t.ack_k);
                    dmem_rdata_i = (acc == t.ack_k) ? t.rdata : $urandom;
                end else begin
                    dmem_ack_i = 1'($urandom);
                    dmem_rdata_i = $urandom;
                end
            end
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL txn_timeout: stall_o still high after 100 cycles, expected retire");
        end
    endtask

    task automatic zero_inputs();
        ALUResult_i = '0; RS2data_i = '0; pc_branch_i = '0; Zero_i = 0; Branch_i = 0;
        MemRead_i = 0; MemWrite_i = 0; MemtoReg_i = 0; RegWrite_i = 0; RDaddr_i = '0;
        dmem_ack_i = 0; dmem_rdata_i = '0;
    endtask

    task automatic check_zero(string tag);
        chk({tag, " RegWrite_o"}, RegWrite_o, 0);
        chk({tag, " MemtoReg_o"}, MemtoReg_o, 0);
        chk({tag, " RDaddr_o"}, RDaddr_o, 0);
        chk({tag, " ReadData_o"}, ReadData_o, 0);
        chk({tag, " ALUResult_o"}, ALUResult_o, 0);
        chk({tag, " dmem_req_o"}, dmem_req_o, 0);
        chk({tag, " dmem_we_o"}, dmem_we_o, 0);
        chk({tag, " dmem_addr_o"}, dmem_addr_o, 0);
        chk({tag, " dmem_wdata_o"}, dmem_wdata_o, 0);
        chk({tag, " err_o"}, err_o, 0);
        chk({tag, " stall_o"}, stall_o, 0);
    endtask

    // Monitor: a cycle sampled with stall_o low retires an instruction at the next edge.
    logic mon_en = 1'b0, prev_valid = 1'b0, prev_stall = 1'b0;
    int stall_run = 0;
    exp_t e;
    always @(negedge clk) begin
        if (mon_en) begin
            if (prev_valid) begin
                if (!prev_stall) begin
                    if (sb_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL retire: got a retire, expected none (scoreboard empty)");
                    end else begin
                        e = sb_q.pop_front();
                        chk("RegWrite_o", RegWrite_o, e.rw);
                        chk("MemtoReg_o", MemtoReg_o, e.mtr);
                        chk("RDaddr_o", RDaddr_o, e.rd);
                        chk("ALUResult_o", ALUResult_o, e.alu);
                        chk("ReadData_o", ReadData_o, e.rdat);
                        chk("dmem_addr_o", dmem_addr_o, e.addr);
                        chk("dmem_wdata_o", dmem_wdata_o, e.wdata);
                        chk("dmem_we_o", dmem_we_o, e.we);
                        chk("err_o", err_o, e.err);
                        chk("stall_cycles", stall_run, e.stall);
                    end
                    stall_run = 0;
                end else begin
                    chk("bubble RegWrite_o", RegWrite_o, 0);
                    chk("bubble MemtoReg_o", MemtoReg_o, 0);
                    chk("bubble RDaddr_o", RDaddr_o, 0);
                end
            end
            chk("PCSrc_o", PCSrc_o, Branch_i & Zero_i);
            chk("pc_branch_o", pc_branch_o, pc_branch_i);
            if (!stall_o) chk("dmem_req_o without stall", dmem_req_o, 0);
            prev_stall = stall_o;
            prev_valid = 1'b1;
            if (stall_o) stall_run++;
        end
    end

    initial begin
        txn_t t;
        rst_i = 1'b0;
        zero_inputs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        @(posedge clk);
        #1;
        rst_i = 1'b1;
        mon_en = 1'b1;

        run_txn(mk(1, 0, 32'h40, 32'h0, 5'd5, 1, 1, 32'h12345678, 3));    // load, ack 3rd
        run_txn(mk(0, 1, 32'h80, 32'hCAFEF00D, 5'd0, 0, 0, 32'h0, 1));   // store, ack 1st
        run_txn(mk(1, 0, 32'h42, 32'h0, 5'd7, 1, 1, 32'h0, 1));          // misaligned
        run_txn(mk(1, 0, 32'h44, 32'h0, 5'd9, 1, 1, 32'h55AA55AA, 0));   // timeout
        run_txn(mk(1, 0, 32'h48, 32'h0, 5'd10, 1, 1, 32'h0BADF00D, 16)); // ack in last cycle
        run_txn(mk(1, 1, 32'h4C, 32'h1111, 5'd11, 0, 0, 32'h2222, 2));   // both -> write
        t = mk(0, 0, 32'h1234, 32'h0, 5'd3, 1, 0, 32'h0, 0);
        t.br = 1'b1; t.zero = 1'b1; t.pcb = 32'h100;
        run_txn(t);                                                        // branch, ALU op
        for (int i = 0; i < 150; i++) run_txn(rand_txn());

        zero_inputs();
        for (int i = 0; i < 5 && sb_q.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        mon_en = 1'b0;
        if (sb_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
        end

        // Reset in the 2nd ACCESS cycle, then a late ack that must be ignored.
        @(posedge clk);
        #1;
        ALUResult_i = 32'h40; MemRead_i = 1'b1; RegWrite_i = 1'b1; RDaddr_i = 5'd5;
        @(posedge clk);
        #1;
        chk("rst-abort req in ACCESS", dmem_req_o, 1);
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        @(posedge clk);
        #1;
        rst_i = 1'b1;
        zero_inputs();
        dmem_ack_i = 1'b1;
        dmem_rdata_i = 32'hFFFFFFFF;
        @(negedge clk);
        check_zero("rst-abort");
        @(posedge clk);
        #1;
        dmem_ack_i = 1'b0;
        @(negedge clk);
        check_zero("rst-abort after ack");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
